// File: rtl/m_wdt_kick_pkg.sv
// Shared watchdog definitions: FSM state codes and the default timing set
// used by both the kicker and the m_reset parameterisation.
package pkg_wdt;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_KICK   = 3'd2,
        ST_STARVE = 3'd3,
        ST_SOFT   = 3'd4,
        ST_HOLD   = 3'd5
    } wdt_state_e;

    localparam int T_START_DEF = 100;
    localparam int T_KICK_DEF  = 1000;
    localparam int T_ALIVE_DEF = 3000;
    localparam int T_SOFT_DEF  = 400;
    localparam int CW_DEF      = 16;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/m_wdt_kick_sync2.sv
// Two-flop synchroniser with synchronous reset; output reads 0 while in reset
// so a fresh power-up always looks like "system still in reset".
module m_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/m_wdt_kick.sv
// Watchdog kicker: toggles wdi while software stays alive, lets the external
// watchdog bite on starvation, and can pulse an open-drain soft reset.
module m_wdt_kick
    import pkg_wdt::*;
#(
    parameter int T_START = T_START_DEF,
    parameter int T_KICK  = T_KICK_DEF,
    parameter int T_ALIVE = T_ALIVE_DEF,
    parameter int T_SOFT  = T_SOFT_DEF,
    parameter int CW      = CW_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sys_rst_n,
    input  logic        en,
    input  logic        alive,
    input  logic        soft_req,
    output logic        wdi_o,
    output logic        wdi_oe,
    output logic        soft_rst_oe,
    output logic [2:0]  state,
    output logic [15:0] kick_cnt
);

    localparam logic [CW-1:0] START_LAST = CW'(T_START - 1);
    localparam logic [CW-1:0] KICK_LAST  = CW'(T_KICK - 1);
    localparam logic [CW-1:0] ALIVE_LAST = CW'(T_ALIVE - 1);
    localparam logic [CW-1:0] SOFT_LAST  = CW'(T_SOFT - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    logic srn;

    wdt_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] alive_cnt_q, alive_cnt_d;
    logic          wdi_q, wdi_d;
    logic          wdi_oe_q, wdi_oe_d;
    logic          soft_oe_q, soft_oe_d;
    logic [15:0]   kick_cnt_q, kick_cnt_d;

    m_sync2 u_sync_srn (
        .clk (clk),
        .rst (rst),
        .d_i (sys_rst_n),
        .q_o (srn)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alive_cnt_d = alive_cnt_q;
        wdi_d       = wdi_q;
        wdi_oe_d    = wdi_oe_q;
        soft_oe_d   = soft_oe_q;
        kick_cnt_d  = kick_cnt_q;

        // Losing system reset overrides everything and releases both lines.
        if (!srn) begin
            state_d   = ST_IDLE;
            wdi_oe_d  = 1'b0;
            soft_oe_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    wdi_oe_d  = 1'b0;
                    soft_oe_d = 1'b0;
                    state_d   = ST_WAIT;
                    cnt_d     = '0;
                end
                ST_WAIT: begin
                    if (soft_req) begin
                        state_d   = ST_SOFT;
                        cnt_d     = '0;
                        wdi_oe_d  = 1'b0;
                        soft_oe_d = 1'b1;
                    end else if (cnt_q == START_LAST) begin
                        state_d     = ST_KICK;
                        cnt_d       = '0;
                        alive_cnt_d = '0;
                        wdi_d       = 1'b0;
                        wdi_oe_d    = 1'b1;
                        kick_cnt_d  = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_KICK: begin
                    if (soft_req) begin
                        state_d   = ST_SOFT;
                        cnt_d     = '0;
                        wdi_oe_d  = 1'b0;
                        soft_oe_d = 1'b1;
                    end else if (!en || (!alive && alive_cnt_q == ALIVE_LAST)) begin
                        state_d = ST_STARVE;
                    end else begin
                        if (cnt_q == KICK_LAST) begin
                            wdi_d      = ~wdi_q;
                            cnt_d      = '0;
                            kick_cnt_d = sat_inc16(kick_cnt_q);
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                        alive_cnt_d = alive ? '0 : alive_cnt_q + CNT_ONE;
                    end
                end
                ST_STARVE: begin
                    if (soft_req) begin
                        state_d   = ST_SOFT;
                        cnt_d     = '0;
                        wdi_oe_d  = 1'b0;
                        soft_oe_d = 1'b1;
                    end else if (alive && en) begin
                        // Restart the kick period so the next toggle is a full period away.
                        state_d     = ST_KICK;
                        cnt_d       = '0;
                        alive_cnt_d = '0;
                    end
                end
                ST_SOFT: begin
                    if (cnt_q == SOFT_LAST) begin
                        state_d   = ST_HOLD;
                        soft_oe_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_HOLD: begin
                    wdi_oe_d  = 1'b0;
                    soft_oe_d = 1'b0;
                end
                default: begin
                    state_d   = ST_IDLE;
                    wdi_oe_d  = 1'b0;
                    soft_oe_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            alive_cnt_q <= '0;
            wdi_q       <= 1'b0;
            wdi_oe_q    <= 1'b0;
            soft_oe_q   <= 1'b0;
            kick_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alive_cnt_q <= alive_cnt_d;
            wdi_q       <= wdi_d;
            wdi_oe_q    <= wdi_oe_d;
            soft_oe_q   <= soft_oe_d;
            kick_cnt_q  <= kick_cnt_d;
        end
    end

    assign wdi_o       = wdi_q;
    assign wdi_oe      = wdi_oe_q;
    assign soft_rst_oe = soft_oe_q;
    assign state       = state_q;
    assign kick_cnt    = kick_cnt_q;

endmodule

// File: tb/tb_m_wdt_kick.sv
// Bench for m_wdt_kick: directed scenarios plus random traffic against a
// timestamp-based reference model, and a second instance for kick_cnt saturation.
module tb_m_wdt_kick;

    localparam int TS  = 10;
    localparam int TK  = 20;
    localparam int TA  = 100;
    localparam int TSF = 5;

    localparam int M_IDLE   = 0;
    localparam int M_WAIT   = 1;
    localparam int M_KICK   = 2;
    localparam int M_STARVE = 3;
    localparam int M_SOFT   = 4;
    localparam int M_HOLD   = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, sys_rst_n, en, alive, soft_req;
    logic        wdi_o, wdi_oe, soft_rst_oe;
    logic [2:0]  state;
    logic [15:0] kick_cnt;

    logic        rst2, sys_rst_n2, en2, alive2, soft_req2;
    logic        wdi_o2, wdi_oe2, soft_rst_oe2;
    logic [2:0]  state2;
    logic [15:0] kick_cnt2;

    m_wdt_kick #(.T_START(TS), .T_KICK(TK), .T_ALIVE(TA), .T_SOFT(TSF), .CW(16)) dut (
        .clk(clk), .rst(rst), .sys_rst_n(sys_rst_n), .en(en), .alive(alive),
        .soft_req(soft_req), .wdi_o(wdi_o), .wdi_oe(wdi_oe),
        .soft_rst_oe(soft_rst_oe), .state(state), .kick_cnt(kick_cnt)
    );

    m_wdt_kick #(.T_START(TS), .T_KICK(1), .T_ALIVE(1000), .T_SOFT(TSF), .CW(16)) dut_sat (
        .clk(clk), .rst(rst2), .sys_rst_n(sys_rst_n2), .en(en2), .alive(alive2),
        .soft_req(soft_req2), .wdi_o(wdi_o2), .wdi_oe(wdi_oe2),
        .soft_rst_oe(soft_rst_oe2), .state(state2), .kick_cnt(kick_cnt2)
    );

    int cmp_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;

    // Reference model: phase plus the timestamps of the events that start each timer.
    int   m_mode = M_IDLE;
    int   t_enter, t_tog, t_alv;
    int   kicks = 0;
    logic hist[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        logic srn_m;
        int   n;
        n = cyc;
        if (rst) begin
            m_mode = M_IDLE;
            kicks  = 0;
            hist   = '{1'b0, 1'b0};
            return;
        end
        srn_m = hist.pop_front();
        hist.push_back(sys_rst_n);
        if (!srn_m) begin
            m_mode = M_IDLE;
            return;
        end
        case (m_mode)
            M_IDLE: begin
                m_mode  = M_WAIT;
                t_enter = n;
            end
            M_WAIT: begin
                if (soft_req) begin
                    m_mode = M_SOFT; t_enter = n;
                end else if (n - t_enter == TS) begin
                    m_mode = M_KICK; kicks = 0; t_tog = n; t_alv = n;
                end
            end
            M_KICK: begin
                if (soft_req) begin
                    m_mode = M_SOFT; t_enter = n;
                end else if (!en || (!alive && n - t_alv == TA)) begin
                    m_mode = M_STARVE;
                end else begin
                    if (n - t_tog == TK) begin
                        kicks++; t_tog = n;
                    end
                    if (alive) t_alv = n;
                end
            end
            M_STARVE: begin
                if (soft_req) begin
                    m_mode = M_SOFT; t_enter = n;
                end else if (alive && en) begin
                    m_mode = M_KICK; t_tog = n; t_alv = n;
                end
            end
            M_SOFT: begin
                if (n - t_enter == TSF) m_mode = M_HOLD;
            end
            default: ;
        endcase
    endtask

    task automatic check_outputs();
        logic exp_oe;
        exp_oe = (m_mode == M_KICK) || (m_mode == M_STARVE);
        check("state", 32'(state), 32'(m_mode));
        check("wdi_oe", 32'(wdi_oe), 32'(exp_oe));
        check("soft_rst_oe", 32'(soft_rst_oe), 32'(m_mode == M_SOFT));
        check("kick_cnt", 32'(kick_cnt), 32'((kicks > 65535) ? 65535 : kicks));
        if (exp_oe) check("wdi_o", 32'(wdi_o), 32'(kicks % 2));
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_step();
        #1;
        check_outputs();
    endtask

    initial begin
        int   k;
        int   hi;
        logic w;

        rst = 1'b1; sys_rst_n = 1'b0; en = 1'b1; alive = 1'b0; soft_req = 1'b0;
        rst2 = 1'b1; sys_rst_n2 = 1'b1; en2 = 1'b1; alive2 = 1'b1; soft_req2 = 1'b0;
        repeat (3) tick();
        check("reset_wdi_o", 32'(wdi_o), 32'd0);
        check("reset_state", 32'(state), 32'd0);
        rst = 1'b0; rst2 = 1'b0;
        repeat (2) tick();

        // Power-up: 2 sync + 1 IDLE + T_START cycles to first drive.
        sys_rst_n = 1'b1;
        k = 0;
        for (int i = 0; i < 40 && !wdi_oe; i++) begin
            tick(); k++;
        end
        check("powerup_latency", 32'(k), 32'd13);
        check("powerup_wdi_o", 32'(wdi_o), 32'd0);
        for (int i = 0; i < 80; i++) begin
            alive = (i == 40);
            tick();
        end
        alive = 1'b0;
        check("kick_cnt_after_80", 32'(kick_cnt), 32'd4);

        // Starvation.
        for (int i = 0; i < 200; i++) begin
            alive = (i % 50 == 0);
            tick();
        end
        alive = 1'b1; tick(); alive = 1'b0;
        k = 0;
        for (int i = 0; i < 200 && state != 3'd3; i++) begin
            tick(); k++;
        end
        check("starve_delay", 32'(k), 32'd100);
        repeat (30) tick();
        check("starve_oe_held", 32'(wdi_oe), 32'd1);
        w = wdi_o;
        alive = 1'b1; tick(); alive = 1'b0;
        check("starve_exit", 32'(state), 32'd2);
        k = 0;
        for (int i = 0; i < 40 && wdi_o == w; i++) begin
            tick(); k++;
        end
        check("toggle_after_resume", 32'(k), 32'd20);

        // Soft reset from KICK.
        soft_req = 1'b1; tick(); soft_req = 1'b0;
        check("soft_enter", 32'(state), 32'd4);
        check("soft_oe_on", 32'(soft_rst_oe), 32'd1);
        check("soft_wdi_released", 32'(wdi_oe), 32'd0);
        hi = 1;
        for (int i = 0; i < 20 && soft_rst_oe; i++) begin
            tick();
            if (soft_rst_oe) hi++;
        end
        check("soft_len", 32'(hi), 32'd5);
        check("hold_state", 32'(state), 32'd5);
        repeat (10) tick();
        sys_rst_n = 1'b0;
        k = 0;
        for (int i = 0; i < 10 && state != 3'd0; i++) begin
            tick(); k++;
        end
        check("hold_to_idle", 32'(k), 32'd3);

        // sys_rst_n drop in the middle of SOFT.
        sys_rst_n = 1'b1;
        repeat (13) tick();
        check("repower_kick", 32'(state), 32'd2);
        soft_req = 1'b1; tick(); soft_req = 1'b0;
        tick();
        sys_rst_n = 1'b0;
        repeat (3) tick();
        check("midsoft_state", 32'(state), 32'd0);
        check("midsoft_soft_oe", 32'(soft_rst_oe), 32'd0);
        check("midsoft_wdi_oe", 32'(wdi_oe), 32'd0);

        // soft_req on the same edge as the alive timeout.
        sys_rst_n = 1'b1;
        repeat (13) tick();
        check("simul_kick", 32'(state), 32'd2);
        repeat (99) tick();
        soft_req = 1'b1; tick(); soft_req = 1'b0;
        check("soft_beats_timeout", 32'(state), 32'd4);

        // en low in KICK.
        sys_rst_n = 1'b0; repeat (3) tick();
        sys_rst_n = 1'b1; repeat (13) tick();
        check("en_kick", 32'(state), 32'd2);
        repeat (5) tick();
        en = 1'b0; tick(); en = 1'b1;
        check("en_low_starve", 32'(state), 32'd3);
        alive = 1'b1; tick(); alive = 1'b0;
        check("en_resume", 32'(state), 32'd2);

        // rst in the middle of KICK.
        repeat (7) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        check("rst_mid_state", 32'(state), 32'd0);
        check("rst_mid_kick_cnt", 32'(kick_cnt), 32'd0);
        check("rst_mid_oe", 32'(wdi_oe), 32'd0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 1999) == 0);
            sys_rst_n = ($urandom_range(0, 299) != 0);
            en        = ($urandom_range(0, 99) != 0);
            alive     = ($urandom_range(0, 39) == 0);
            soft_req  = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0; sys_rst_n = 1'b1; en = 1'b1; soft_req = 1'b0;

        // Let the T_KICK=1 instance run past 65535 toggles.
        while (cyc < 70000) begin
            alive = (cyc % 50 == 0);
            tick();
        end
        alive = 1'b0;
        check("sat_kick_cnt", 32'(kick_cnt2), 32'h0000FFFF);
        check("sat_state", 32'(state2), 32'd2);
        check("sat_wdi_oe", 32'(wdi_oe2), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
